// File: rtl/rx_ctrl_pkg.sv
// Shared types and widths for the serial receive link controller.
package rx_ctrl_pkg;

    localparam int unsigned ERR_W   = 8;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned FLUSH_W = 4;
    localparam int unsigned GOOD_W  = 4;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StFlush,
        StRun,
        StLost
    } state_e;

    // Where the controller goes once a flush has drained.
    typedef enum logic {
        RetSync,
        RetRun
    } ret_e;

    function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/rx_link_ctrl_if.sv
// Signal bundle between the serial receive front end / FIFO and rx_link_ctrl.
interface rx_link_ctrl_if;
    import rx_ctrl_pkg::*;

    logic             ival;
    logic             imk;
    logic             iempty;
    logic             ifull;
    logic             iclr_stat;
    logic             oflush;
    logic             oswch;
    logic             ord_en;
    logic             olock;
    logic             oovf;
    logic [ERR_W-1:0] oerr_cnt;

    modport master (
        output ival, imk, iempty, ifull, iclr_stat,
        input  oflush, oswch, ord_en, olock, oovf, oerr_cnt
    );

    modport slave (
        input  ival, imk, iempty, ifull, iclr_stat,
        output oflush, oswch, ord_en, olock, oovf, oerr_cnt
    );

endinterface

// File: rtl/rx_frame_cnt.sv
// Counts received bits between markers and flags whether each marker closed a full frame.
module rx_frame_cnt
    import rx_ctrl_pkg::*;
#(
    parameter int unsigned FRAME_BITS = 64
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic ival_i,
    input  logic imk_i,
    output logic mk_match_o,
    output logic mk_mismatch_o
);

    localparam logic [CNT_W-1:0] FrameLen = CNT_W'(FRAME_BITS);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             len_ok;

    // A bit arriving with the marker opens the next frame.
    always_comb begin
        cnt_d = cnt_q;
        if (imk_i) begin
            cnt_d = ival_i ? CNT_W'(1) : '0;
        end else if (ival_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign len_ok        = (cnt_q == FrameLen);
    assign mk_match_o    = imk_i && len_ok;
    assign mk_mismatch_o = imk_i && !len_ok;

endmodule

// File: rtl/rx_link_ctrl.sv
// Receive link sequencer: acquires frame lock, drives FIFO flushes and recovers from
// framing errors, FIFO overflow and link loss without software help.
module rx_link_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int unsigned FRAME_BITS  = 64,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned TIMEOUT     = 4096,
    parameter int unsigned FLUSH_CYC   = 2
) (
    input logic           clk,
    input logic           reset,
    rx_link_ctrl_if.slave bus
);

    localparam int unsigned        TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]   TmoMax    = TMO_W'(TIMEOUT - 1);
    localparam logic [FLUSH_W-1:0] FlushLoad = FLUSH_W'(FLUSH_CYC - 1);
    localparam logic [GOOD_W-1:0]  GoodLast  = GOOD_W'(LOCK_FRAMES - 1);

    state_e             state_q;
    ret_e               ret_q;
    logic [GOOD_W-1:0]  good_q;
    logic [FLUSH_W-1:0] fcnt_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               oflush_q, oswch_q, ord_en_q, olock_q;
    logic               ovf_q, ovf_d;
    logic [ERR_W-1:0]   err_q, err_d;

    logic mk_match, mk_mismatch;
    logic tmo_hit, ovf_ev, err_ev;

    rx_frame_cnt #(
        .FRAME_BITS (FRAME_BITS)
    ) u_frame_cnt (
        .clk_i         (clk),
        .reset_i       (reset),
        .ival_i        (bus.ival),
        .imk_i         (bus.imk),
        .mk_match_o    (mk_match),
        .mk_mismatch_o (mk_mismatch)
    );

    // Idle time only counts once the link has been seen; IDLE keeps it reloaded.
    always_ff @(posedge clk) begin
        if (reset || bus.ival || (state_q == StIdle)) begin
            tmo_q <= '0;
        end else if (tmo_q != TmoMax) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    assign tmo_hit = !bus.ival && (tmo_q == TmoMax);
    assign ovf_ev  = (state_q == StRun) && bus.ival && bus.ifull;
    assign err_ev  = (state_q == StRun) && mk_mismatch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            ret_q    <= RetSync;
            good_q   <= '0;
            fcnt_q   <= '0;
            oflush_q <= 1'b0;
            oswch_q  <= 1'b0;
            ord_en_q <= 1'b0;
            olock_q  <= 1'b0;
        end else begin
            ord_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.imk) begin
                        state_q <= StSync;
                        good_q  <= '0;
                    end
                end
                StSync: begin
                    if (tmo_hit) begin
                        state_q  <= StLost;
                        oflush_q <= 1'b1;
                        fcnt_q   <= FlushLoad;
                        good_q   <= '0;
                    end else if (mk_match) begin
                        if (good_q == GoodLast) begin
                            state_q  <= StFlush;
                            ret_q    <= RetRun;
                            oflush_q <= 1'b1;
                            fcnt_q   <= FlushLoad;
                            good_q   <= '0;
                        end else begin
                            good_q <= good_q + 1'b1;
                        end
                    end else if (mk_mismatch) begin
                        good_q <= '0;
                    end
                end
                StFlush: begin
                    if (fcnt_q == '0) begin
                        oflush_q <= 1'b0;
                        if (ret_q == RetRun) begin
                            state_q  <= StRun;
                            olock_q  <= 1'b1;
                            ord_en_q <= !bus.iempty;
                        end else begin
                            state_q <= StSync;
                        end
                    end else begin
                        fcnt_q <= fcnt_q - 1'b1;
                    end
                end
                StRun: begin
                    if (mk_match) begin
                        oswch_q <= ~oswch_q;
                    end
                    if (tmo_hit) begin
                        state_q  <= StLost;
                        olock_q  <= 1'b0;
                        oflush_q <= 1'b1;
                        fcnt_q   <= FlushLoad;
                        good_q   <= '0;
                    end else if (ovf_ev || err_ev) begin
                        // Coincident overflow and framing error share one flush.
                        state_q  <= StFlush;
                        ret_q    <= RetSync;
                        olock_q  <= 1'b0;
                        oflush_q <= 1'b1;
                        fcnt_q   <= FlushLoad;
                        good_q   <= '0;
                    end else begin
                        ord_en_q <= !bus.iempty;
                    end
                end
                StLost: begin
                    if (fcnt_q == '0) begin
                        oflush_q <= 1'b0;
                        state_q  <= StIdle;
                    end else begin
                        fcnt_q <= fcnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    oflush_q <= 1'b0;
                    olock_q  <= 1'b0;
                end
            endcase
        end
    end

    // A fresh event beats a same-cycle clear so it is never lost.
    always_comb begin
        ovf_d = ovf_q;
        err_d = err_q;
        if (ovf_ev) begin
            ovf_d = 1'b1;
        end else if (bus.iclr_stat) begin
            ovf_d = 1'b0;
        end
        if (err_ev) begin
            err_d = bus.iclr_stat ? ERR_W'(1) : err_inc(err_q);
        end else if (bus.iclr_stat) begin
            err_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            err_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            err_q <= err_d;
        end
    end

    assign bus.oflush   = oflush_q;
    assign bus.oswch    = oswch_q;
    assign bus.ord_en   = ord_en_q;
    assign bus.olock    = olock_q;
    assign bus.oovf     = ovf_q;
    assign bus.oerr_cnt = err_q;

endmodule

// File: doc/rx_link_ctrl.md
# rx_link_ctrl

Sequencing controller for the serial receive path: watches bit-valid and marker pulses from the serial interface plus the local FIFO flags. It acquires frame lock, drives the FIFO synchronous clear, enables the marker reader, and toggles the buffer-switch line per frame. It recovers automatically from framing errors, FIFO overflow and link loss, so the receive datapath needs no software intervention.

## Interface
- FRAME_BITS, 64: data bits expected between consecutive markers (2..65535)
- LOCK_FRAMES, 2: consecutive correct frames required for lock (1..15)
- TIMEOUT, 4096: clk cycles without bit-valid before link is declared lost
- FLUSH_CYC, 2: cycles oflush is held high per flush (1..15)
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high
- ival  in  1  one-cycle pulse: received bit written toward FIFO
- imk  in  1  one-cycle pulse: frame marker detected (already synchronised upstream)
- iempty  in  1  FIFO empty flag
- ifull  in  1  FIFO full flag
- iclr_stat  in  1  pulse: clears oovf and oerr_cnt
- oflush  out  1  FIFO sclr / downstream flush
- oswch  out  1  buffer-switch line, toggles per accepted frame
- ord_en  out  1  read enable permission for marker reader
- olock  out  1  frame lock achieved
- oovf  out  1  sticky FIFO overflow flag
- oerr_cnt  out  8  saturating framing-error count

## Operation
- States: IDLE, SYNC, FLUSH, RUN, LOST. Reset → IDLE; all outputs 0, counters 0.
- Bit counter (16 bit): increments on ival. On imk it reloads to 0, or to 1 if ival is in the same cycle; that bit belongs to the new frame.
- IDLE: first imk → SYNC. Bits before the first marker are ignored.
- SYNC: on each imk compare bit count to FRAME_BITS. Match → good_cnt+1; mismatch → good_cnt=0. When good_cnt reaches LOCK_FRAMES → FLUSH, with return target RUN.
- FLUSH: oflush=1 for exactly FLUSH_CYC cycles, then go to the return target. ival/imk are ignored for locking, but the bit counter keeps running so frame alignment is kept.
- RUN: olock=1; ord_en = !iempty; oswch toggles on each imk whose count matches.
  - Mismatched imk → oerr_cnt+1 (saturates at 255), olock=0, FLUSH with return target SYNC, good_cnt=0.
  - ival & ifull in the same cycle → oovf=1, olock=0, FLUSH with return target SYNC.
  - If overflow and framing mismatch occur in the same cycle, both are recorded and only one flush is issued.
- Timeout counter: reloads on every ival. Reaching TIMEOUT in SYNC or RUN → LOST.
- LOST: olock=0, good_cnt=0, one flush of FLUSH_CYC cycles, then IDLE.
- iclr_stat clears oovf/oerr_cnt. If a new overflow or error occurs in the same cycle, that event wins: flag=1, count=1.
- reset asserted mid-flush aborts it: oflush drops on the next edge.

## Timing
- All outputs registered; every response appears 1 clk after the causing input edge.
- oswch toggles 1 cycle after the qualifying imk.
- oflush is high for FLUSH_CYC cycles starting the cycle after the decision.
- ord_en follows iempty with 1 cycle latency; it is forced 0 while oflush=1 and in any state other than RUN.
- olock rises in the first RUN cycle, after the lock flush completes.
- Timeout is detected when TIMEOUT cycles have elapsed since the last ival.

## Structure
- Package rx_ctrl_pkg:
  - state enum (IDLE, SYNC, FLUSH, RUN, LOST)
  - ERR_W=8 and counter width constants
  - flush-return-target enum
- Sub-module rx_frame_cnt: bit counter, marker compare, and a match/mismatch pulse per imk.
- Top level holds the FSM, flush timer, timeout counter and status registers.

## Test plan
- Lock: FRAME_BITS=64, LOCK_FRAMES=2, three clean 64-bit frames → oflush high 2 cycles after the 3rd imk, olock=1, oswch toggles once per later imk.
- Framing error in RUN: a 63-bit frame → oerr_cnt=1, olock=0, flush, re-lock after 2 good frames; 256 errors → oerr_cnt stays 255.
- Overflow: ifull=1 with ival in RUN → oovf=1 sticky through re-lock; iclr_stat clears it. iclr_stat coincident with a new overflow → oovf=1.
- Link loss: stop ival for 4096 cycles → LOST, one 2-cycle flush, IDLE, olock=0; markers resume → normal re-lock.
- Simultaneous imk+ival: bit counted in the new frame (count=1); a 64-bit frame still matches.
- Reset during FLUSH → next cycle all outputs 0, state IDLE.
